timer_dev: RTL and testbench

- Memory-mapped countdown timer peripheral; the responder behind the bridge for CPU word accesses to the timer windows 0x7f00–0x7f0b (Timer0) and 0x7f10–0x7f1b (Timer1).
- One instance per window.
- The data-memory stage already faults any sub-word access or any store to offset 0x8. This block therefore sees only aligned word reads and writes.
- Produces an interrupt request to CP0.

---
 rtl/timer_dev.sv | 241 ++++++++++++++++++++++++
 tb/tb_timer_dev.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer peripheral with level interrupt
//
// Purpose:
//    Word-addressed countdown timer that sits behind the bus bridge, one
//    instance per timer window.  Software programs PRESET and CTRL; the FSM
//    loads COUNT from PRESET, counts down to zero and then either raises a
//    sticky interrupt (one-shot) or reloads and pulses the interrupt
//    (auto-reload).
//
// Build option:
//    TIMER_PRESCALE_EN - when defined, COUNT steps once every PRESCALE clock
//                        cycles instead of every cycle.
//
// Ports:
//    clk    - system clock
//    reset  - synchronous, active-high reset
//    addr   - word offset (bus address bits [3:2])
//    we     - write strobe, write commits at posedge clk
//    wdata  - write data
//    rdata  - read data for the register selected by addr (combinational)
//    irq    - level interrupt request to CP0
//
// Register map (by addr):
//    0 CTRL   : [0] EN, [2:1] MODE, [3] IM; upper bits read as zero
//    1 PRESET : read/write
//    2 COUNT  : read-only
//    3 -      : reads zero, writes ignored

module timer_dev #(
   parameter int CNT_W    = 32,
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   // Elaboration-time sanity checks on the build parameters.
   generate
      if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
         $error("timer_dev: CNT_W must be in 1..32");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("timer_dev: PRESCALE must be at least 1");
      end
   endgenerate

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   localparam logic [1:0] MODE_RELOAD = 2'b01;

   // ------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------
   logic [3:0]       ctrl_q,     ctrl_d;
   logic [CNT_W-1:0] preset_q,   preset_d;
   logic [CNT_W-1:0] count_q,    count_d;
   logic [1:0]       state_q,    state_d;
   logic             irq_pend_q, irq_pend_d;

   logic       ctrl_en;
   logic [1:0] ctrl_mode;
   logic       ctrl_im;

   assign ctrl_en   = ctrl_q[0];
   assign ctrl_mode = ctrl_q[2:1];
   assign ctrl_im   = ctrl_q[3];

   // ------------------------------------------------------------------
   // Bus write decode
   // ------------------------------------------------------------------
   logic wr_ctrl;
   logic wr_preset;

   assign wr_ctrl   = we && (addr == A_CTRL);
   assign wr_preset = we && (addr == A_PRESET);

   // ------------------------------------------------------------------
   // Count step enable: every cycle, or once per PRESCALE cycles
   // ------------------------------------------------------------------
   logic step_en;

`ifdef TIMER_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_q, ps_d;

   assign step_en = (ps_q == PS_LAST);

   // The prescaler restarts whenever a period begins so every period is
   // exactly P*PRESCALE counting cycles long.
   always_comb begin
      ps_d = ps_q;
      case (state_q)
         S_IDLE, S_LOAD: ps_d = '0;
         S_CNT: begin
            if (ctrl_en) begin
               ps_d = step_en ? '0 : ps_q + PS_W'(1);
            end
         end
         default: ps_d = ps_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end
`else
   assign step_en = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Timer FSM.  Decisions use the registered CTRL, so a write on the same
   // edge only influences the following cycle.
   // ------------------------------------------------------------------
   logic int_clr_en;
   logic int_set_pend;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      int_clr_en   = 1'b0;
      int_set_pend = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctrl_en) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_en) begin
               state_d = S_IDLE;
            end else if (step_en) begin
               // COUNT<=1 rather than ==1 so that PRESET=0 behaves like 1.
               if (count_q <= CNT_W'(1)) begin
                  count_d = '0;
                  state_d = S_INT;
               end else begin
                  count_d = count_q - CNT_W'(1);
               end
            end
         end
         S_INT: begin
            if (ctrl_mode == MODE_RELOAD) begin
               state_d = S_LOAD;
            end else begin
               // One-shot, and the reserved modes fall back to one-shot.
               int_clr_en   = 1'b1;
               int_set_pend = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Register next-state: software writes win over FSM side effects
   // ------------------------------------------------------------------
   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_ctrl) begin
         ctrl_d = wdata[3:0];
      end else if (int_clr_en) begin
         ctrl_d = {ctrl_q[3:1], 1'b0};
      end
   end

   always_comb begin
      preset_d = preset_q;
      if (wr_preset) begin
         preset_d = wdata[CNT_W-1:0];
      end
   end

   // Any CTRL/PRESET write acknowledges the interrupt, even if the one-shot
   // completes on the same edge.
   always_comb begin
      irq_pend_d = irq_pend_q;
      if (wr_ctrl || wr_preset) begin
         irq_pend_d = 1'b0;
      end else if (int_set_pend) begin
         irq_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         state_q    <= S_IDLE;
         irq_pend_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         state_q    <= state_d;
         irq_pend_q <= irq_pend_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Auto-reload requests last exactly the one cycle spent in INT; one-shot
   // requests are held by irq_pend_q until software writes CTRL or PRESET.
   assign irq = ctrl_im &
                (irq_pend_q | ((state_q == S_INT) && (ctrl_mode == MODE_RELOAD)));

   always_comb begin
      rdata = '0;
      case (addr)
         A_CTRL:   rdata[3:0]       = ctrl_q;
         A_PRESET: rdata[CNT_W-1:0] = preset_q;
         A_COUNT:  rdata[CNT_W-1:0] = count_q;
         default:  rdata            = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed scoreboard bench for timer_dev

module tb_timer_dev;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   timer_dev dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      we    = 1'b1;
      wdata = d;
      tick();
      we    = 1'b0;
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic chk_rd(input string tag, input logic [1:0] a);
      addr = a;
      #1;
      check(tag, rdata);
   endtask

   task automatic chk_irq(input string tag);
      check(tag, {31'b0, irq});
   endtask

   // COUNT after edge e of an auto-reload run with PRESET=3, EN at edge 0.
   function automatic logic [31:0] reload_cnt(input int e);
      case (e % 5)
         2:       return 32'd3;
         3:       return 32'd2;
         4:       return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      push(0); chk_rd("rst_ctrl", 2'd0);
      push(0); chk_rd("rst_preset", 2'd1);
      push(0); chk_rd("rst_count", 2'd2);
      push(0); chk_rd("rst_addr3", 2'd3);
      push(0); chk_irq("rst_irq");

      // One-shot, PRESET=5
      wr(2'd1, 32'd5);
      push(5); chk_rd("os_preset", 2'd1);
      wr(2'd0, 32'h9);
      tick();
      for (int e = 2; e <= 7; e++) begin
         tick();
         push(32'(7 - e)); chk_rd("os_count", 2'd2);
      end
      tick();
      push(1);     chk_irq("os_irq_set");
      push(32'h8); chk_rd("os_ctrl_en_clr", 2'd0);
      repeat (3) tick();
      push(1); chk_irq("os_irq_hold");
      push(0); chk_rd("os_count_idle", 2'd2);
      wr(2'd1, 32'd5);
      push(0); chk_irq("os_irq_clr");

      // Auto-reload, IM=1
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int e = 1; e <= 15; e++) begin
         tick();
         push({31'b0, (e % 5) == 0}); chk_irq("ar_irq");
         push(reload_cnt(e));         chk_rd("ar_count", 2'd2);
      end
      wr(2'd0, 32'h0);
      repeat (4) tick();

      // Auto-reload, IM=0, then IM re-enabled at edge 8
      wr(2'd0, 32'h3);
      for (int e = 1; e <= 15; e++) begin
         if (e == 8) begin
            addr  = 2'd0;
            wdata = 32'hB;
            we    = 1'b1;
         end
         tick();
         we = 1'b0;
         push({31'b0, (e >= 8) && ((e % 5) == 0)}); chk_irq("ar_im_irq");
         if (e >= 2) begin
            push(reload_cnt(e)); chk_rd("ar_im_count", 2'd2);
         end
      end
      wr(2'd0, 32'h0);
      repeat (4) tick();

      // Collision: CTRL write on the edge INT clears EN
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      repeat (4) tick();
      wr(2'd0, 32'h9);
      push(32'h9); chk_rd("col_ctrl", 2'd0);
      push(0);     chk_irq("col_irq_clr");
      tick();
      tick();
      push(2); chk_rd("col_restart", 2'd2);
      wr(2'd0, 32'h0);
      repeat (3) tick();

      // PRESET=0 behaves like 1
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      repeat (3) tick();
      push(0); chk_irq("p0_irq_int");
      tick();
      push(1); chk_irq("p0_irq_set");
      wr(2'd1, 32'd5);

      // Mid-count stop, PRESET write during CNT, COUNT read-only
      wr(2'd1, 32'd8);
      wr(2'd0, 32'h1);
      repeat (4) tick();
      push(6);  chk_rd("mid_count6", 2'd2);
      wr(2'd1, 32'd20);
      push(5);  chk_rd("pre_wr_cnt", 2'd2);
      tick();
      push(4);  chk_rd("mid_count4", 2'd2);
      wr(2'd0, 32'h0);
      push(3);  chk_rd("mid_last_dec", 2'd2);
      tick();
      push(3);  chk_rd("mid_frozen", 2'd2);
      tick();
      tick();
      wr(2'd2, 32'h55);
      push(3);  chk_rd("cnt_ro", 2'd2);
      push(20); chk_rd("pre_wr", 2'd1);
      push(0);  chk_rd("mid_ctrl", 2'd0);

      // Reset asserted mid-count
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      repeat (5) tick();
      push(2); chk_rd("mr_count2", 2'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push(0); chk_rd("mr_ctrl", 2'd0);
      push(0); chk_rd("mr_preset", 2'd1);
      push(0); chk_rd("mr_count", 2'd2);
      push(0); chk_rd("mr_addr3", 2'd3);
      push(0); chk_irq("mr_irq");

      // One-shot latency with PRESET=2
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
`ifdef TIMER_PRESCALE_EN
      repeat (6) tick();
      push(1); chk_rd("ps_count_e6", 2'd2);
      repeat (3) tick();
      push(1); chk_rd("ps_count_e9", 2'd2);
      tick();
      push(0); chk_rd("ps_count_e10", 2'd2);
      tick();
      push(1); chk_irq("ps_irq");
`else
      repeat (3) tick();
      push(1); chk_rd("lat_count_e3", 2'd2);
      tick();
      push(0); chk_rd("lat_count_e4", 2'd2);
      tick();
      push(1); chk_irq("lat_irq");
`endif

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
